mem_initiator: RTL and testbench

Requester-side end of the memory link.
- Accepts single read/write commands from a local client over a valid/ready port.
- Issues each command as one link transaction (egress request path) to the memory responder at address MEM_ADDR.
- For reads, collects the response from the ingress response path.
- Returns one completion per command, with a timeout/error indication. Sits between a core/NI client and one memory responder.

---
 rtl/mem_initiator.sv | 181 ++++++++++++++++++
 tb/tb_mem_initiator.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - requester-side memory link initiator: one command, one link transaction, one completion

package ni_defs;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef enum logic {
        TX_RD = 1'b0,
        TX_WR = 1'b1
    } tx_kind_e;

    typedef struct packed {
        tx_kind_e            kind;
        logic [ADDR_W-1:0]   mem_addr;
        logic [DATA_W-1:0]   data;
    } tx_t;
endpackage

// One direction of the memory link: the source presents src_rdy with tx,
// the target accepts with tgt_rdy; a transfer happens when both are high.
interface link;
    logic         src_rdy;
    logic         tgt_rdy;
    ni_defs::tx_t tx;

    modport egress  (output src_rdy, output tx, input  tgt_rdy);
    modport ingress (input  src_rdy, input  tx, output tgt_rdy);
endinterface

module mem_initiator #(
    parameter logic [ni_defs::ADDR_W-1:0] MEM_ADDR  = '0,
    parameter int                         TIMEOUT   = 16,
    parameter int                         TIMEOUT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_wr,
    input  logic [ni_defs::DATA_W-1:0] cmd_data,

    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [ni_defs::DATA_W-1:0] rsp_data,

    link.egress                        reqpath,
    link.ingress                       rsppath
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Last wait-counter value before an abort; the counter starts at 0 on
    // entry to a wait state, so this gives exactly TIMEOUT cycles per state.
    localparam bit                   TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [TIMEOUT_W-1:0] WCNT_LAST  = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                      state;
    state_t                      state_d;
    logic [TIMEOUT_W-1:0]        wcnt;
    logic [TIMEOUT_W-1:0]        wcnt_d;
    logic                        op_wr;
    logic                        op_wr_d;
    logic [ni_defs::DATA_W-1:0]  op_data;
    logic [ni_defs::DATA_W-1:0]  op_data_d;
    logic                        rsp_valid_d;
    logic                        rsp_err_d;
    logic [ni_defs::DATA_W-1:0]  rsp_data_d;
    logic                        expired;

    // Threshold reached: an abort happens this cycle unless the awaited
    // handshake also happens (completion wins).
    assign expired = TIMEOUT_EN && (wcnt == WCNT_LAST);

    // Handshake-side outputs decode straight from the state so that an
    // asynchronous reset drops them in the same cycle.
    assign cmd_ready          = (state == IDLE);
    assign reqpath.src_rdy    = (state == REQ);
    assign rsppath.tgt_rdy    = (state == RSP);
    assign reqpath.tx         = '{kind:     ni_defs::tx_kind_e'(op_wr),
                                  mem_addr: MEM_ADDR,
                                  data:     op_data};

    // State and datapath registers; completion flags are registered so the
    // pulse appears the cycle after the finishing handshake or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            op_wr     <= 1'b0;
            op_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_d;
            wcnt      <= wcnt_d;
            op_wr     <= op_wr_d;
            op_data   <= op_data_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_data  <= rsp_data_d;
        end
    end

    // Next-state logic: accept in IDLE, issue in REQ, collect in RSP, and
    // fall back to IDLE with an error completion when the wait expires.
    always_comb begin
        state_d     = state;
        wcnt_d      = wcnt;
        op_wr_d     = op_wr;
        op_data_d   = op_data;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_wr_d   = cmd_wr;
                    op_data_d = cmd_data;
                    wcnt_d    = '0;
                    state_d   = REQ;
                end
            end

            REQ: begin
                if (reqpath.tgt_rdy) begin
                    if (op_wr) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = RSP;
                        wcnt_d  = '0;
                    end
                end else if (expired) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (TIMEOUT_EN) begin
                    wcnt_d = wcnt + 1'b1;
                end
            end

            RSP: begin
                if (rsppath.src_rdy) begin
                    rsp_data_d  = rsppath.tx.data;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else if (expired) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (TIMEOUT_EN) begin
                    wcnt_d = wcnt + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ap_req_addr: assert property (@(posedge clk) disable iff (rst)
        reqpath.src_rdy |-> (reqpath.tx.mem_addr == MEM_ADDR));

    ap_req_stable: assert property (@(posedge clk) disable iff (rst)
        (reqpath.src_rdy && !reqpath.tgt_rdy) |=> ($stable(op_wr) && $stable(op_data)));

    ap_one_wait: assert property (@(posedge clk) disable iff (rst)
        $onehot0({state == REQ, state == RSP}));

    ap_rsp_pulse: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - self-checking bench for mem_initiator with a latency/outcome reference model
module tb_mem_initiator;
    import ni_defs::*;

    localparam int                T  = 16;
    localparam logic [ADDR_W-1:0] MA = 4'h5;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    link req_if ();
    link rsp_if ();

    mem_initiator #(.MEM_ADDR(MA), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .reqpath   (req_if),
        .rsppath   (rsp_if)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Responder: ready after req_delay waiting cycles, response after rsp_delay.
    int                req_delay = 0;
    int                rsp_delay = 0;
    logic [DATA_W-1:0] rsp_word  = '0;
    int                req_cnt;
    int                rsp_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) req_cnt <= 0;
        else if (req_if.src_rdy && !req_if.tgt_rdy) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rsp_cnt <= 0;
        else if (rsp_if.tgt_rdy && !rsp_if.src_rdy) rsp_cnt <= rsp_cnt + 1;
        else rsp_cnt <= 0;
    end

    assign req_if.tgt_rdy = req_if.src_rdy && (req_cnt >= req_delay);
    assign rsp_if.src_rdy = rsp_if.tgt_rdy && (rsp_cnt >= rsp_delay);
    assign rsp_if.tx      = '{kind: TX_RD, mem_addr: MA, data: rsp_word};

    // Reference model: outcome of one command from the responder delays.
    logic [DATA_W-1:0] exp_rdata = '0;

    function automatic bit model_err(input bit wr, input int dreq, input int drsp);
        return (dreq >= T) || (!wr && drsp >= T);
    endfunction

    function automatic int model_lat(input bit wr, input int dreq, input int drsp);
        if (dreq >= T) return T + 1;
        if (wr) return dreq + 2;
        if (drsp >= T) return dreq + T + 2;
        return dreq + drsp + 3;
    endfunction

    function automatic int model_req_cycles(input int dreq);
        return (dreq >= T) ? T : dreq + 1;
    endfunction

    function automatic int model_rsp_cycles(input bit wr, input int dreq, input int drsp);
        if (wr || dreq >= T) return 0;
        return (drsp >= T) ? T : drsp + 1;
    endfunction

    task automatic run_txn(input string tag, input bit wr, input logic [DATA_W-1:0] data,
                           input int dreq, input int drsp, input logic [DATA_W-1:0] rword);
        int lat = 0;
        int src_cyc = 0;
        int rsp_cyc = 0;
        int bad_fields = 0;
        bit seen = 0;
        bit e_err;
        int e_lat;
        logic [DATA_W-1:0] e_data;
        tx_kind_e e_kind;

        e_err  = model_err(wr, dreq, drsp);
        e_lat  = model_lat(wr, dreq, drsp);
        e_kind = wr ? TX_WR : TX_RD;
        if (!e_err && !wr) exp_rdata = rword;
        e_data = exp_rdata;

        req_delay = dreq;
        rsp_delay = drsp;
        rsp_word  = rword;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_data  = data;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s cmd_ready at issue: got %b expected 1", tag, cmd_ready);
        end
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat == 1) cmd_valid = 1'b0;
            if (req_if.src_rdy) begin
                src_cyc++;
                if (req_if.tx.kind !== e_kind || req_if.tx.data !== data || req_if.tx.mem_addr !== MA)
                    bad_fields++;
            end
            if (rsp_if.tgt_rdy) rsp_cyc++;
            if (rsp_valid) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s no completion within %0d cycles", tag, lat);
        end else begin
            tests_run += 6;
            if (lat !== e_lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d expected %0d", tag, lat, e_lat);
            end
            if (rsp_err !== e_err) begin
                tests_failed++;
                $display("FAIL %s rsp_err: got %b expected %b", tag, rsp_err, e_err);
            end
            if (rsp_data !== e_data) begin
                tests_failed++;
                $display("FAIL %s rsp_data: got %h expected %h", tag, rsp_data, e_data);
            end
            if (cmd_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s cmd_ready at completion: got %b expected 1", tag, cmd_ready);
            end
            if (src_cyc !== model_req_cycles(dreq) || rsp_cyc !== model_rsp_cycles(wr, dreq, drsp)) begin
                tests_failed++;
                $display("FAIL %s wait cycles: got req %0d rsp %0d expected req %0d rsp %0d", tag,
                         src_cyc, rsp_cyc, model_req_cycles(dreq), model_rsp_cycles(wr, dreq, drsp));
            end
            if (bad_fields !== 0) begin
                tests_failed++;
                $display("FAIL %s request fields: got %0d bad cycles expected 0", tag, bad_fields);
            end
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s rsp_valid pulse width: got %b expected 0", tag, rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_data  = '0;
        repeat (2) @(negedge clk);
        tests_run += 2;
        if (req_if.src_rdy !== 1'b0 || rsp_if.tgt_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset link rdy: got src %b tgt %b expected 0 0", req_if.src_rdy, rsp_if.tgt_rdy);
        end
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== '0) begin
            tests_failed++;
            $display("FAIL reset rsp: got v %b e %b d %h expected 0 0 0", rsp_valid, rsp_err, rsp_data);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run += 2;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset cmd_ready: got %b expected 1", cmd_ready);
        end
        if (req_if.tx.mem_addr !== MA || req_if.tx.data !== '0) begin
            tests_failed++;
            $display("FAIL reset tx: got addr %h data %h expected %h 0", req_if.tx.mem_addr, req_if.tx.data, MA);
        end
    endtask

    task automatic test_write();
        run_txn("write_deadbeef", 1'b1, 32'hDEADBEEF, 3, 0, 32'h0);
    endtask

    task automatic test_read();
        run_txn("read_deadbeef", 1'b0, 32'h0, 0, 0, 32'hDEADBEEF);
    endtask

    task automatic test_timeout();
        run_txn("write_timeout", 1'b1, 32'h12345678, 1000, 0, 32'h0);
        run_txn("read_rsp_timeout", 1'b0, 32'h0, 2, 1000, 32'hAAAA5555);
    endtask

    task automatic test_boundary();
        run_txn("write_boundary", 1'b1, 32'hCAFEF00D, T - 1, 0, 32'h0);
        run_txn("read_boundary", 1'b0, 32'h0, 0, T - 1, 32'h0BADBEEF);
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        req_delay = 1000;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_data  = 32'h55AA55AA;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_if.src_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid in REQ: got src_rdy %b expected 1", req_if.src_rdy);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (req_if.src_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid src_rdy drop: got %b expected 0", req_if.src_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid idle after reset: got %0d bad cycles expected 0", stray);
        end
        run_txn("write_after_reset", 1'b1, 32'h0000BEEF, 0, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [DATA_W-1:0] hs_data[$];
        int nrsp = 0;
        int nerr = 0;
        int idx = 0;
        int cyc = 0;
        bit pending = 0;
        int bad_gap = 0;
        req_delay = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_data  = 32'd1;
        while (nrsp < 4 && cyc < 40) begin
            if (pending) begin
                idx++;
                if (idx < 4) cmd_data = DATA_W'(idx + 1);
                else cmd_valid = 1'b0;
                pending = 0;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc.push_back(cyc);
                pending = 1;
            end
            if (req_if.src_rdy && req_if.tgt_rdy) hs_data.push_back(req_if.tx.data);
            if (rsp_valid) begin
                nrsp++;
                if (rsp_err) nerr++;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        tests_run += 3;
        if (nrsp !== 4 || nerr !== 0) begin
            tests_failed++;
            $display("FAIL b2b completions: got %0d (%0d err) expected 4 (0 err)", nrsp, nerr);
        end
        if (hs_data.size() !== 4 || hs_data[0] !== 32'd1 || hs_data[1] !== 32'd2 ||
            hs_data[2] !== 32'd3 || hs_data[3] !== 32'd4) begin
            tests_failed++;
            $display("FAIL b2b handshake data: got %0d handshakes expected 4 in order 1..4", hs_data.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++)
            if (acc_cyc[i] - acc_cyc[i-1] != 2) bad_gap++;
        if (acc_cyc.size() !== 4 || bad_gap !== 0) begin
            tests_failed++;
            $display("FAIL b2b accept spacing: got %0d accepts %0d bad gaps expected 4 accepts 0 bad gaps",
                     acc_cyc.size(), bad_gap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn("random", 1'($urandom_range(0, 1)), DATA_W'($urandom), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 20)), DATA_W'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
